dmem_bus_bridge: RTL

Memory-stage bus bridge between the pipeline's memory stage and an external word-addressed data bus with a request/ready/response handshake. It captures a load or store present in the M stage and drives one bus transaction, holding the pipeline through StallM until the access completes. It returns load data on ReadDataM and flags misaligned or timed-out accesses. It sits directly downstream of the execute/memory pipeline registers and replaces a single-cycle data memory.

---
 rtl/dmem_bus_bridge.sv | 120 ++++++++++++
 1 files changed

// File: rtl/dmem_bus_bridge.sv
// Memory-stage bridge: turns an M-stage load/store into one request/ready/response
// bus transaction, stalling the pipeline until it completes, errors or times out.
module dmem_bus_bridge #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWriteM,
    input  logic        MemReadM,
    input  logic [31:0] ALU_ResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        ErrM,
    output logic        bus_req,
    output logic        bus_we,
    output logic [29:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);
    // state | meaning
    // IDLE  | waiting for a load/store in M
    // REQ   | bus_req driven, waiting for bus_ready
    // RESP  | read accepted, waiting for bus_rvalid
    // DONE  | access finished, instruction leaves M this cycle
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0] state;
    logic [7:0] cnt;
    logic       err_flag;
    logic       mem_op;
    logic       aligned;
    logic       hs_done;
    logic       expire;

    assign mem_op  = MemReadM | MemWriteM;
    assign aligned = (ALU_ResultM[1:0] == 2'b00);

    always_comb begin
        hs_done = 1'b0;
        case (state)
            REQ:     hs_done = bus_ready;
            RESP:    hs_done = bus_rvalid;
            default: hs_done = 1'b0;
        endcase
    end

    // >= rather than == so a read accepted on the last REQ cycle still expires in RESP
    assign expire = (cnt >= CNT_LAST) && !hs_done;

    assign StallM = (state == REQ) || (state == RESP) || ((state == IDLE) && mem_op);
    assign ErrM   = (state == DONE) && err_flag;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            err_flag  <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 30'd0;
            bus_wdata <= 32'd0;
            ReadDataM <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        if (aligned) begin
                            bus_req   <= 1'b1;
                            bus_we    <= MemWriteM;
                            bus_addr  <= ALU_ResultM[31:2];
                            bus_wdata <= WriteDataM;
                            cnt       <= 8'd0;
                            err_flag  <= 1'b0;
                            state     <= REQ;
                        end else begin
                            ReadDataM <= 32'd0;
                            err_flag  <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                REQ: begin
                    cnt <= cnt + 8'd1;
                    if (bus_ready) begin
                        bus_req <= 1'b0;
                        state   <= bus_we ? DONE : RESP;
                    end else if (expire) begin
                        bus_req   <= 1'b0;
                        ReadDataM <= 32'd0;
                        err_flag  <= 1'b1;
                        state     <= DONE;
                    end
                end
                RESP: begin
                    cnt <= cnt + 8'd1;
                    if (bus_rvalid) begin
                        ReadDataM <= bus_rdata;
                        state     <= DONE;
                    end else if (expire) begin
                        ReadDataM <= 32'd0;
                        err_flag  <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: begin
                    err_flag <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule
